oled_seq_ctrl: RTL and testbench

OLED_SEQ_CTRL -- requirements
Module: oled_seq_ctrl

---
 rtl/oled_pkg.sv | 66 ++++++
 rtl/flex_counter.sv | 35 +++
 rtl/oled_seq_ctrl.sv | 232 +++++++++++++++++++++++
 tb/tb_oled_seq_ctrl.sv | 347 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/oled_pkg.sv
// Shared constants, FSM encodings and the power-on init table for the OLED sequencer.
package oled_pkg;

    localparam logic [1:0] OP_FILL     = 2'b00;
    localparam logic [1:0] OP_OFF      = 2'b01;
    localparam logic [1:0] OP_ON       = 2'b10;
    localparam logic [1:0] OP_CONTRAST = 2'b11;

    localparam logic [7:0] CTRL_CMD  = 8'h00;
    localparam logic [7:0] CTRL_DATA = 8'h40;

    localparam int INIT_LEN = 25;
    localparam int WIN_LEN  = 7;

    typedef enum logic [2:0] {
        ST_RST_LOW,
        ST_RST_WAIT,
        ST_INIT,
        ST_IDLE,
        ST_SET_WIN,
        ST_FILL,
        ST_SIMPLE,
        ST_ERROR
    } state_t;

    // Sub-steps of every I2C write: present first byte, pulse start, stream bytes.
    typedef enum logic [1:0] {
        PH_LOAD,
        PH_START,
        PH_RUN
    } phase_t;

    function automatic logic [7:0] init_byte(input int pages, input logic [7:0] idx);
        logic [7:0] b;
        case (idx)
            8'd0:    b = 8'hAE;
            8'd1:    b = 8'hD5;
            8'd2:    b = 8'h80;
            8'd3:    b = 8'hA8;
            8'd4:    b = 8'(pages * 8 - 1);
            8'd5:    b = 8'hD3;
            8'd6:    b = 8'h00;
            8'd7:    b = 8'h40;
            8'd8:    b = 8'h8D;
            8'd9:    b = 8'h14;
            8'd10:   b = 8'h20;
            8'd11:   b = 8'h00;
            8'd12:   b = 8'hA1;
            8'd13:   b = 8'hC8;
            8'd14:   b = 8'hDA;
            8'd15:   b = (pages == 8) ? 8'h12 : 8'h02;
            8'd16:   b = 8'h81;
            8'd17:   b = 8'hCF;
            8'd18:   b = 8'hD9;
            8'd19:   b = 8'hF1;
            8'd20:   b = 8'hDB;
            8'd21:   b = 8'h40;
            8'd22:   b = 8'hA4;
            8'd23:   b = 8'hA6;
            8'd24:   b = 8'hAF;
            default: b = 8'h00;
        endcase
        return b;
    endfunction

endpackage

// File: rtl/flex_counter.sv
// Up-counter with synchronous clear; flags when the count equals the rollover value.
module flex_counter #(
    parameter int W = 4
) (
    input  logic         i_clk,
    input  logic         i_rst_n,
    input  logic         i_clear,
    input  logic         i_count_en,
    input  logic [W-1:0] i_rollover_val,
    output logic         o_rollover
);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (i_clear) begin
            count_d = '0;
        end else if (i_count_en) begin
            count_d = count_q + W'(1);
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign o_rollover = (count_q == i_rollover_val);

endmodule

// File: rtl/oled_seq_ctrl.sv
// SSD1306-style OLED sequencer: hardware reset, init table, and user commands
// (fill / on / off / contrast) issued as I2C write transactions.
module oled_seq_ctrl
    import oled_pkg::*;
#(
    parameter int         CLK_FREQ  = 100_000_000,
    parameter int         RST_US    = 10_000,
    parameter int         COLS      = 128,
    parameter int         PAGES     = 8,
    parameter logic [6:0] DEV_ADDR  = 7'h3C,
    parameter int         MAX_CHUNK = 16
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_cmd_valid,
    output logic       o_cmd_ready,
    input  logic [1:0] i_cmd_op,
    input  logic [7:0] i_cmd_arg,
    output logic       o_busy,
    output logic       o_init_done,
    output logic       o_error,
    output logic       o_oled_rst,
    output logic [6:0] o_i2c_addr,
    output logic       o_i2c_start,
    output logic [7:0] o_i2c_byte_cnt,
    output logic [7:0] o_i2c_tx_data,
    input  logic       i_i2c_tx_req,
    input  logic       i_i2c_done,
    input  logic       i_i2c_nack
);

    localparam int RST_CYCLES = CLK_FREQ / 1_000_000 * RST_US;
    localparam int RW         = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
    localparam int TOTAL      = COLS * PAGES;
    localparam int SW         = $clog2(TOTAL + 1);

    state_t       state_q, state_d;
    phase_t       phase_q, phase_d;
    logic [7:0]   idx_q, idx_d;
    logic [7:0]   tx_data_q, tx_data_d;
    logic [7:0]   byte_cnt_q, byte_cnt_d;
    logic [1:0]   op_q, op_d;
    logic [7:0]   arg_q, arg_d;
    logic [SW-1:0] sent_q, sent_d;
    logic         init_done_q, init_done_d;
    logic         cnt_en;
    logic         cnt_clr;
    logic         rst_term;
    logic         txn_state;

    flex_counter #(
        .W (RW)
    ) u_rst_timer (
        .i_clk          (i_clk),
        .i_rst_n        (i_rst_n),
        .i_clear        (cnt_clr),
        .i_count_en     (cnt_en),
        .i_rollover_val (RW'(RST_CYCLES - 1)),
        .o_rollover     (rst_term)
    );

    function automatic logic [7:0] seq_byte(input state_t st, input logic [1:0] op,
                                            input logic [7:0] arg, input logic [7:0] idx);
        logic [7:0] b;
        b = CTRL_CMD;
        case (st)
            ST_INIT:    b = (idx == 8'd0) ? CTRL_CMD : init_byte(PAGES, idx - 8'd1);
            ST_SET_WIN: begin
                case (idx)
                    8'd1:    b = 8'h21;
                    8'd3:    b = 8'(COLS - 1);
                    8'd4:    b = 8'h22;
                    8'd6:    b = 8'(PAGES - 1);
                    default: b = 8'h00;
                endcase
            end
            ST_FILL:    b = (idx == 8'd0) ? CTRL_DATA : arg;
            ST_SIMPLE: begin
                if (idx != 8'd0) begin
                    case (op)
                        OP_OFF:  b = 8'hAE;
                        OP_ON:   b = 8'hAF;
                        default: b = (idx == 8'd1) ? 8'h81 : arg;
                    endcase
                end
            end
            default:    b = CTRL_CMD;
        endcase
        return b;
    endfunction

    // Byte count of a data transaction: control byte plus up to MAX_CHUNK pattern bytes.
    function automatic logic [7:0] chunk_cnt(input int remaining);
        int c;
        c = (remaining > MAX_CHUNK) ? MAX_CHUNK : remaining;
        return 8'(c + 1);
    endfunction

    assign txn_state = (state_q == ST_INIT) || (state_q == ST_SET_WIN) ||
                       (state_q == ST_FILL) || (state_q == ST_SIMPLE);

    always_comb begin
        int next_sent;
        state_d     = state_q;
        phase_d     = phase_q;
        idx_d       = idx_q;
        tx_data_d   = tx_data_q;
        byte_cnt_d  = byte_cnt_q;
        op_d        = op_q;
        arg_d       = arg_q;
        sent_d      = sent_q;
        init_done_d = init_done_q;
        cnt_en      = 1'b0;
        cnt_clr     = 1'b0;
        next_sent   = int'(sent_q) + int'(byte_cnt_q) - 1;

        case (state_q)
            ST_RST_LOW: begin
                cnt_en = 1'b1;
                if (rst_term) begin
                    cnt_clr = 1'b1;
                    state_d = ST_RST_WAIT;
                end
            end
            ST_RST_WAIT: begin
                cnt_en = 1'b1;
                if (rst_term) begin
                    cnt_clr    = 1'b1;
                    state_d    = ST_INIT;
                    phase_d    = PH_LOAD;
                    idx_d      = '0;
                    tx_data_d  = CTRL_CMD;
                    byte_cnt_d = 8'(INIT_LEN + 1);
                end
            end
            ST_IDLE: begin
                if (i_cmd_valid) begin
                    op_d      = i_cmd_op;
                    arg_d     = i_cmd_arg;
                    phase_d   = PH_LOAD;
                    idx_d     = '0;
                    tx_data_d = CTRL_CMD;
                    if (i_cmd_op == OP_FILL) begin
                        state_d    = ST_SET_WIN;
                        byte_cnt_d = 8'(WIN_LEN);
                    end else begin
                        state_d    = ST_SIMPLE;
                        byte_cnt_d = (i_cmd_op == OP_CONTRAST) ? 8'd3 : 8'd2;
                    end
                end
            end
            ST_ERROR: begin
                state_d = ST_ERROR;
            end
            default: begin
                case (phase_q)
                    PH_LOAD:  phase_d = PH_START;
                    PH_START: phase_d = PH_RUN;
                    default: begin
                        // NACK takes priority over a coincident done.
                        if (i_i2c_nack) begin
                            state_d = ST_ERROR;
                        end else if (i_i2c_done) begin
                            phase_d = PH_LOAD;
                            idx_d   = '0;
                            case (state_q)
                                ST_INIT: begin
                                    init_done_d = 1'b1;
                                    state_d     = ST_IDLE;
                                end
                                ST_SET_WIN: begin
                                    state_d    = ST_FILL;
                                    tx_data_d  = CTRL_DATA;
                                    sent_d     = '0;
                                    byte_cnt_d = chunk_cnt(TOTAL);
                                end
                                ST_FILL: begin
                                    if (next_sent >= TOTAL) begin
                                        state_d = ST_IDLE;
                                    end else begin
                                        sent_d     = SW'(next_sent);
                                        tx_data_d  = CTRL_DATA;
                                        byte_cnt_d = chunk_cnt(TOTAL - next_sent);
                                    end
                                end
                                default: state_d = ST_IDLE;
                            endcase
                        end else if (i_i2c_tx_req) begin
                            idx_d     = idx_q + 8'd1;
                            tx_data_d = seq_byte(state_q, op_q, arg_q, idx_q + 8'd1);
                        end
                    end
                endcase
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_q     <= ST_RST_LOW;
            phase_q     <= PH_LOAD;
            idx_q       <= '0;
            tx_data_q   <= '0;
            byte_cnt_q  <= '0;
            op_q        <= '0;
            arg_q       <= '0;
            sent_q      <= '0;
            init_done_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            phase_q     <= phase_d;
            idx_q       <= idx_d;
            tx_data_q   <= tx_data_d;
            byte_cnt_q  <= byte_cnt_d;
            op_q        <= op_d;
            arg_q       <= arg_d;
            sent_q      <= sent_d;
            init_done_q <= init_done_d;
        end
    end

    assign o_oled_rst     = (state_q != ST_RST_LOW);
    assign o_i2c_start    = txn_state && (phase_q == PH_START);
    assign o_cmd_ready    = (state_q == ST_IDLE);
    assign o_busy         = (state_q != ST_IDLE) && (state_q != ST_ERROR);
    assign o_error        = (state_q == ST_ERROR);
    assign o_init_done    = init_done_q;
    assign o_i2c_addr     = DEV_ADDR;
    assign o_i2c_byte_cnt = byte_cnt_q;
    assign o_i2c_tx_data  = tx_data_q;

endmodule

// File: tb/tb_oled_seq_ctrl.sv
// Directed + randomized bench for oled_seq_ctrl with a behavioural I2C master and
// an expected-transaction model built from the command rules.
module tb_oled_seq_ctrl;

    localparam int P_CLK   = 1_000_000;
    localparam int P_RSTUS = 5;
    localparam int P_COLS  = 10;
    localparam int P_PAGES = 4;
    localparam int P_MAXC  = 16;
    localparam int RST_CYC = P_CLK / 1_000_000 * P_RSTUS;

    localparam logic [1:0] C_FILL = 2'b00;
    localparam logic [1:0] C_OFF  = 2'b01;
    localparam logic [1:0] C_ON   = 2'b10;
    localparam logic [1:0] C_CON  = 2'b11;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [1:0] cmd_op;
    logic [7:0] cmd_arg;
    logic       busy, init_done, error, oled_rst;
    logic [6:0] i2c_addr;
    logic       i2c_start;
    logic [7:0] i2c_byte_cnt, i2c_tx_data;
    logic       tx_req, i2c_done, i2c_nack;

    int total = 0;
    int bad   = 0;

    logic [7:0] exp_q[$];
    int         exp_cnt_q[$];

    oled_seq_ctrl #(
        .CLK_FREQ  (P_CLK),
        .RST_US    (P_RSTUS),
        .COLS      (P_COLS),
        .PAGES     (P_PAGES),
        .DEV_ADDR  (7'h3C),
        .MAX_CHUNK (P_MAXC)
    ) dut (
        .i_clk          (clk),
        .i_rst_n        (rst_n),
        .i_cmd_valid    (cmd_valid),
        .o_cmd_ready    (cmd_ready),
        .i_cmd_op       (cmd_op),
        .i_cmd_arg      (cmd_arg),
        .o_busy         (busy),
        .o_init_done    (init_done),
        .o_error        (error),
        .o_oled_rst     (oled_rst),
        .o_i2c_addr     (i2c_addr),
        .o_i2c_start    (i2c_start),
        .o_i2c_byte_cnt (i2c_byte_cnt),
        .o_i2c_tx_data  (i2c_tx_data),
        .i_i2c_tx_req   (tx_req),
        .i_i2c_done     (i2c_done),
        .i_i2c_nack     (i2c_nack)
    );

    always #5 clk = ~clk;

    initial begin
        #500_000;
        $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset(input string tag);
        chk({tag, " oled_rst"}, oled_rst, 0);
        chk({tag, " start"}, i2c_start, 0);
        chk({tag, " ready"}, cmd_ready, 0);
        chk({tag, " busy"}, busy, 1);
        chk({tag, " init_done"}, init_done, 0);
        chk({tag, " error"}, error, 0);
        chk({tag, " byte_cnt"}, i2c_byte_cnt, 0);
        chk({tag, " tx_data"}, i2c_tx_data, 0);
    endtask

    // Expected byte stream of the power-on init transaction.
    task automatic model_init();
        logic [7:0] tab[25];
        tab = '{8'hAE, 8'hD5, 8'h80, 8'hA8, 8'(P_PAGES * 8 - 1), 8'hD3, 8'h00, 8'h40,
                8'h8D, 8'h14, 8'h20, 8'h00, 8'hA1, 8'hC8, 8'hDA,
                (P_PAGES == 8) ? 8'h12 : 8'h02, 8'h81, 8'hCF, 8'hD9, 8'hF1,
                8'hDB, 8'h40, 8'hA4, 8'hA6, 8'hAF};
        exp_cnt_q.push_back(26);
        exp_q.push_back(8'h00);
        for (int i = 0; i < 25; i++) exp_q.push_back(tab[i]);
    endtask

    // Expected transactions for one user command.
    task automatic model_cmd(input logic [1:0] op, input logic [7:0] arg);
        int rem;
        int c;
        case (op)
            C_FILL: begin
                exp_cnt_q.push_back(7);
                exp_q.push_back(8'h00); exp_q.push_back(8'h21); exp_q.push_back(8'h00);
                exp_q.push_back(8'(P_COLS - 1)); exp_q.push_back(8'h22);
                exp_q.push_back(8'h00); exp_q.push_back(8'(P_PAGES - 1));
                rem = P_COLS * P_PAGES;
                while (rem > 0) begin
                    c = (rem < P_MAXC) ? rem : P_MAXC;
                    exp_cnt_q.push_back(c + 1);
                    exp_q.push_back(8'h40);
                    for (int i = 0; i < c; i++) exp_q.push_back(arg);
                    rem -= c;
                end
            end
            C_OFF: begin
                exp_cnt_q.push_back(2);
                exp_q.push_back(8'h00); exp_q.push_back(8'hAE);
            end
            C_ON: begin
                exp_cnt_q.push_back(2);
                exp_q.push_back(8'h00); exp_q.push_back(8'hAF);
            end
            default: begin
                exp_cnt_q.push_back(3);
                exp_q.push_back(8'h00); exp_q.push_back(8'h81); exp_q.push_back(arg);
            end
        endcase
    endtask

    // I2C master model. act: 0 normal, 1 nack (with coincident done) at byte act_at,
    // 2 assert reset at byte act_at.
    task automatic run_txn(input string tag, input int act, input int act_at, output int waited);
        logic [7:0] pre_tx;
        logic [7:0] pre_cnt;
        bit         seen;
        int         ecnt;
        logic [7:0] b;
        seen    = 0;
        waited  = 0;
        pre_tx  = i2c_tx_data;
        pre_cnt = i2c_byte_cnt;
        for (int k = 0; k < 400; k++) begin
            tick();
            waited++;
            if (i2c_start) begin
                seen = 1;
                break;
            end
            pre_tx  = i2c_tx_data;
            pre_cnt = i2c_byte_cnt;
        end
        chk({tag, " start seen"}, seen, 1);
        ecnt = (exp_cnt_q.size() > 0) ? exp_cnt_q.pop_front() : 0;
        if (!seen) begin
            for (int j = 0; j < ecnt; j++) void'(exp_q.pop_front());
            return;
        end
        chk({tag, " byte_cnt"}, i2c_byte_cnt, ecnt);
        chk({tag, " setup before start"}, {pre_cnt, pre_tx}, {i2c_byte_cnt, i2c_tx_data});
        chk({tag, " ready in txn"}, cmd_ready, 0);
        chk({tag, " busy in txn"}, busy, 1);
        tick();
        chk({tag, " start one cycle"}, i2c_start, 0);
        for (int i = 0; i < ecnt; i++) begin
            b = exp_q.pop_front();
            chk($sformatf("%s byte%0d", tag, i), i2c_tx_data, b);
            if (act != 0 && i == act_at) begin
                for (int j = i + 1; j < ecnt; j++) void'(exp_q.pop_front());
                if (act == 1) begin
                    i2c_nack = 1'b1;
                    i2c_done = 1'b1;
                    tick();
                    i2c_nack = 1'b0;
                    i2c_done = 1'b0;
                end else begin
                    rst_n = 1'b0;
                    tick();
                    check_reset({tag, " midrst"});
                    rst_n = 1'b1;
                    exp_q.delete();
                    exp_cnt_q.delete();
                end
                return;
            end
            tx_req = 1'b1;
            tick();
            tx_req = 1'b0;
            repeat ($urandom_range(0, 2)) tick();
        end
        i2c_done = 1'b1;
        tick();
        i2c_done = 1'b0;
    endtask

    task automatic power_up(input string tag);
        int  n;
        int  w;
        bit  rose;
        bit  st;
        exp_q.delete();
        exp_cnt_q.delete();
        n    = 0;
        rose = 0;
        st   = 0;
        while (!rose && n < 1000) begin
            tick();
            n++;
            if (i2c_start) st = 1;
            if (oled_rst) rose = 1;
        end
        chk({tag, " oled_rst low cycles"}, n, RST_CYC);
        chk({tag, " no start while low"}, st, 0);
        chk({tag, " init_done before init"}, init_done, 0);
        model_init();
        // One setup cycle presents the first byte before the start pulse.
        run_txn({tag, " init"}, 0, 0, w);
        chk({tag, " cycles high to start"}, w, RST_CYC + 1);
        chk({tag, " init_done"}, init_done, 1);
        chk({tag, " ready after init"}, cmd_ready, 1);
    endtask

    task automatic send_cmd(input string tag, input logic [1:0] op, input logic [7:0] arg);
        bit ok;
        ok = 0;
        for (int k = 0; k < 50; k++) begin
            if (cmd_ready) begin
                ok = 1;
                break;
            end
            tick();
        end
        chk({tag, " ready before cmd"}, ok, 1);
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_arg   = arg;
        tick();
        cmd_valid = 1'b0;
        cmd_op    = 2'($urandom_range(0, 3));
        cmd_arg   = 8'($urandom_range(0, 255));
        chk({tag, " ready drops"}, cmd_ready, 0);
        model_cmd(op, arg);
    endtask

    task automatic do_cmd(input string tag, input logic [1:0] op, input logic [7:0] arg);
        int ntx;
        int w;
        send_cmd(tag, op, arg);
        ntx = exp_cnt_q.size();
        for (int t = 0; t < ntx; t++) run_txn($sformatf("%s t%0d", tag, t), 0, 0, w);
        chk({tag, " ready after done"}, cmd_ready, 1);
        chk({tag, " idle not busy"}, busy, 0);
    endtask

    initial begin
        int         w;
        logic [7:0] tx_before;
        bit         hs, he, hb, hr;
        rst_n     = 1'b0;
        cmd_valid = 1'b0;
        cmd_op    = 2'b00;
        cmd_arg   = 8'h00;
        tx_req    = 1'b0;
        i2c_done  = 1'b0;
        i2c_nack  = 1'b0;
        repeat (3) tick();
        check_reset("por");
        chk("i2c_addr", i2c_addr, 7'h3C);
        rst_n = 1'b1;
        power_up("pu1");

        do_cmd("contrast7f", C_CON, 8'h7F);
        do_cmd("fillAA", C_FILL, 8'hAA);

        // Handshake pulses while idle must have no effect.
        tx_before = i2c_tx_data;
        tx_req = 1'b1;   tick(); tx_req = 1'b0;
        i2c_done = 1'b1; tick(); i2c_done = 1'b0;
        i2c_nack = 1'b1; tick(); i2c_nack = 1'b0;
        hs = 0;
        repeat (10) begin
            tick();
            if (i2c_start) hs = 1;
        end
        chk("stray no start", hs, 0);
        chk("stray error", error, 0);
        chk("stray ready", cmd_ready, 1);
        chk("stray tx_data", i2c_tx_data, tx_before);

        for (int n = 0; n < 10; n++) begin
            logic [1:0] op;
            logic [7:0] arg;
            op  = 2'($urandom_range(0, 3));
            arg = 8'($urandom_range(0, 255));
            do_cmd($sformatf("rnd%0d op%0d", n, op), op, arg);
        end

        // NACK (with a coincident done) on the third fill chunk.
        send_cmd("nack", C_FILL, 8'h3C);
        run_txn("nack win", 0, 0, w);
        run_txn("nack c1", 0, 0, w);
        run_txn("nack c2", 0, 0, w);
        run_txn("nack c3", 1, 2, w);
        hs = 0; he = 0; hb = 0; hr = 0;
        cmd_valid = 1'b1;
        repeat (100) begin
            tick();
            if (i2c_start) hs = 1;
            if (error !== 1'b1) he = 1;
            if (busy !== 1'b0) hb = 1;
            if (cmd_ready !== 1'b0) hr = 1;
        end
        cmd_valid = 1'b0;
        chk("nack hold no start", hs, 0);
        chk("nack hold error", he, 0);
        chk("nack hold busy", hb, 0);
        chk("nack hold ready", hr, 0);

        rst_n = 1'b0;
        tick();
        check_reset("err rst");
        rst_n = 1'b1;
        power_up("pu2");

        // Reset asserted in the middle of a data chunk.
        send_cmd("midfill", C_FILL, 8'h55);
        run_txn("midfill win", 0, 0, w);
        run_txn("midfill c1", 2, 3, w);
        power_up("pu3");

        do_cmd("final on", C_ON, 8'h00);
        do_cmd("final off", C_OFF, 8'h00);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
